dac_spi_tx: RTL and testbench

- Downstream consumer of the sine generator's 12-bit SIN / SIN_L sample.
- Serialises each sample into a 32-bit SPI write-and-update frame for an external quad 12-bit DAC (LTC2624-style).
- One frame per accepted start strobe; the generator's sample-rate ce drives start.
- Frame content and SCK rate are fixed by parameters.

---
 rtl/dac_spi_tx_if.sv | 17 +
 rtl/dac_spi_tx.sv | 139 +++++++++++++
 tb/tb_dac_spi_tx.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_spi_tx_if.sv
// Sample-in / SPI-out bundle for dac_spi_tx: the start/din strobe from the
// sine generator, status pulses back, and the three DAC pins.
interface dac_spi_tx_if;
  localparam int unsigned SAMPLE_W = 12;

  logic                start;
  logic [SAMPLE_W-1:0] din;
  logic                busy;
  logic                done;
  logic                ovf;
  logic                sck;
  logic                mosi;
  logic                cs_n;

  modport master (output start, din, input busy, done, ovf, sck, mosi, cs_n);
  modport slave  (input start, din, output busy, done, ovf, sck, mosi, cs_n);
endinterface

// File: rtl/dac_spi_tx.sv
// Serialises one 12-bit sample per start strobe into a 32-bit LTC2624-style
// write-and-update SPI frame. Define DAC_PENDING_EN for a one-entry pending buffer.
module dac_spi_tx #(
  parameter int unsigned HALF_DIV = 2,
  parameter logic [3:0]  CMD      = 4'h3,
  parameter logic [3:0]  ADR      = 4'hF
) (
  input  logic         clk,
  input  logic         rst_n,
  dac_spi_tx_if.slave  bus
);
  localparam int unsigned FRAME_W  = 32;
  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned HCNT_W   = 8;
  localparam int unsigned BCNT_W   = 5;
  localparam logic [HCNT_W-1:0] HRELOAD  = HCNT_W'(HALF_DIV - 1);
  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t              state;
  logic [FRAME_W-1:0]  sreg;
  logic [HCNT_W-1:0]   hcnt;
  logic [BCNT_W-1:0]   bcnt;
  logic                busy_q, done_q, ovf_q, sck_q, mosi_q, cs_n_q;

  logic                launch_c;
  logic                drop_c;
  logic [SAMPLE_W-1:0] launch_din_c;
  logic [FRAME_W-1:0]  launch_frame_c;

  assign launch_frame_c = {8'h00, CMD, ADR, launch_din_c, 4'h0};

`ifdef DAC_PENDING_EN
  logic                pend;
  logic [SAMPLE_W-1:0] pend_din;

  // A stored sample takes priority and relaunches right out of the done cycle.
  assign launch_c     = (state == IDLE) && (pend || (bus.start && !done_q));
  assign launch_din_c = pend ? pend_din : bus.din;
  assign drop_c       = bus.start && pend && (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      pend_din <= '0;
    end else if ((state == IDLE) && pend) begin
      pend <= bus.start;
      if (bus.start) pend_din <= bus.din;
    end else if (bus.start && !launch_c) begin
      pend     <= 1'b1;
      pend_din <= bus.din;
    end
  end
`else
  // The done cycle still counts as busy, so a start there is dropped.
  assign launch_c     = (state == IDLE) && !done_q && bus.start;
  assign launch_din_c = bus.din;
  assign drop_c       = bus.start && !launch_c;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sreg   <= '0;
      hcnt   <= '0;
      bcnt   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      sck_q  <= 1'b0;
      mosi_q <= 1'b0;
      cs_n_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      ovf_q  <= drop_c;
      case (state)
        IDLE: begin
          if (launch_c) begin
            state  <= SETUP;
            sreg   <= launch_frame_c;
            mosi_q <= launch_frame_c[FRAME_W-1];
            cs_n_q <= 1'b0;
            busy_q <= 1'b1;
            sck_q  <= 1'b0;
            hcnt   <= HRELOAD;
            bcnt   <= BIT_LAST;
          end
        end
        SETUP: begin
          if (hcnt == '0) begin
            state <= SHIFT;
            sck_q <= 1'b1;
            hcnt  <= HRELOAD;
          end else begin
            hcnt <= hcnt - HCNT_W'(1);
          end
        end
        // mosi only moves on the falling sck edge, keeping it stable for the DAC
        SHIFT: begin
          if (hcnt != '0) begin
            hcnt <= hcnt - HCNT_W'(1);
          end else if (sck_q) begin
            sck_q  <= 1'b0;
            sreg   <= {sreg[FRAME_W-2:0], 1'b0};
            mosi_q <= sreg[FRAME_W-2];
            hcnt   <= HRELOAD;
          end else if (bcnt == '0) begin
            state  <= HOLD;
            mosi_q <= 1'b0;
            hcnt   <= HRELOAD;
          end else begin
            sck_q <= 1'b1;
            bcnt  <= bcnt - BCNT_W'(1);
            hcnt  <= HRELOAD;
          end
        end
        HOLD: begin
          if (hcnt == '0) begin
            state  <= IDLE;
            cs_n_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            hcnt <= hcnt - HCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.sck  = sck_q;
  assign bus.mosi = mosi_q;
  assign bus.cs_n = cs_n_q;
endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: HALF_DIV=2 and HALF_DIV=1 instances, a pin-level SPI
// capture monitor, and expected frames built from the DAC frame layout.
module tb_dac_spi_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dac_spi_tx_if bus0 ();
  dac_spi_tx_if bus1 ();

  logic [1:0]  st = 2'b00;
  logic [11:0] dn [2];

  assign bus0.start = st[0];
  assign bus0.din   = dn[0];
  assign bus1.start = st[1];
  assign bus1.din   = dn[1];

  dac_spi_tx #(.HALF_DIV(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  dac_spi_tx #(.HALF_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  logic [1:0] cs, sck, mosi, busy, done, ovf;
  assign cs   = {bus1.cs_n, bus0.cs_n};
  assign sck  = {bus1.sck,  bus0.sck};
  assign mosi = {bus1.mosi, bus0.mosi};
  assign busy = {bus1.busy, bus0.busy};
  assign done = {bus1.done, bus0.done};
  assign ovf  = {bus1.ovf,  bus0.ovf};

  typedef struct {
    int          k;
    logic [31:0] frame;
    int          nbits;
    int          low;
    int          gap;
  } rec_t;

  rec_t        recs[$];
  int          low[2], nb[2], hi[2], gap[2], ndone[2], novf[2], nviol[2];
  logic [31:0] sh[2];
  logic [1:0]  pcs = 2'b11, psck = 2'b00, pmosi = 2'b00;

  int nvec = 0;
  int nerr = 0;

  // Pin-level observer: one record per cs_n low window, captured on sck rises.
  initial begin
    for (int k = 0; k < 2; k++) begin
      low[k] = 0; nb[k] = 0; hi[k] = 0; gap[k] = 0;
      ndone[k] = 0; novf[k] = 0; nviol[k] = 0; sh[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!cs[k] && pcs[k]) begin
          gap[k] = hi[k]; low[k] = 0; nb[k] = 0; sh[k] = '0;
        end
        if (!cs[k]) begin
          low[k]++;
          if (sck[k] && !psck[k]) begin
            sh[k] = {sh[k][30:0], mosi[k]};
            nb[k]++;
          end
        end else begin
          hi[k]++;
        end
        if (cs[k] && !pcs[k]) begin
          rec_t r;
          r.k = k; r.frame = sh[k]; r.nbits = nb[k]; r.low = low[k]; r.gap = gap[k];
          recs.push_back(r);
          hi[k] = 1;
        end
        if (done[k]) ndone[k]++;
        if (ovf[k]) novf[k]++;
        if (done[k] && !(cs[k] && !pcs[k])) nviol[k]++;
        if (busy[k] == cs[k]) nviol[k]++;
        if (cs[k] && sck[k]) nviol[k]++;
        if (sck[k] && psck[k] && (mosi[k] != pmosi[k])) nviol[k]++;
      end
      pcs = cs; psck = sck; pmosi = mosi;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_frame(input logic [11:0] d);
    return 32'h003F_0000 | (32'(d) << 4);
  endfunction

  function automatic logic [31:0] pins(input int k);
    return 32'({cs[k], sck[k], mosi[k], busy[k], done[k], ovf[k]});
  endfunction

  function automatic int count_recs(input int k);
    int n = 0;
    foreach (recs[i]) if (recs[i].k == k) n++;
    return n;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input int k, input logic [11:0] d);
    dn[k] = d;
    st[k] = 1'b1;
    tick();
    st[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int lim);
    int n = 0;
    while (!done[k] && n < lim) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done[k]), 32'd1);
  endtask

  task automatic pop_rec(input int k, output rec_t r);
    int idx = -1;
    foreach (recs[i]) if (idx < 0 && recs[i].k == k) idx = i;
    check("rec_present", 32'(idx >= 0), 32'd1);
    r.k = k; r.frame = '0; r.nbits = 0; r.low = 0; r.gap = 0;
    if (idx >= 0) begin
      r = recs[idx];
      recs.delete(idx);
    end
  endtask

  task automatic check_frame(input int k, input logic [11:0] d, input int hd);
    rec_t r;
    pop_rec(k, r);
    check("frame", r.frame, exp_frame(d));
    check("nbits", 32'(r.nbits), 32'd32);
    check("cs_low", 32'(r.low), 32'(66 * hd));
  endtask

  task automatic send(input int k, input logic [11:0] d);
    int dn0;
    dn0 = ndone[k];
    pulse(k, d);
    check("cs_fall_1cyc", pins(k), 32'b000100);
    wait_done(k, 300);
    tick();
    check_frame(k, d, k == 0 ? 2 : 1);
    check("done_count", 32'(ndone[k] - dn0), 32'd1);
  endtask

  initial begin
    rec_t        r;
    int          ov0, dn0;
    logic [11:0] d;
    dn[0] = '0;
    dn[1] = '0;
    repeat (3) tick();
    check("reset_pins0", pins(0), 32'b100000);
    check("reset_pins1", pins(1), 32'b100000);
    rst_n = 1'b1;
    repeat (2) tick();

    send(0, 12'hABC);
    send(0, 12'h800);
    send(0, 12'h000);
    send(0, 12'hFFF);

    for (int i = 0; i < 12; i++) begin
      d = 12'($urandom);
      send(int'($urandom_range(0, 1)), d);
      repeat ($urandom_range(0, 3)) tick();
    end

    // Overrun: second start ~10 cycles into the frame.
    ov0 = novf[0];
    dn0 = ndone[0];
    pulse(0, 12'h123);
    repeat (9) tick();
    pulse(0, 12'h456);
    wait_done(0, 300);
    tick();
`ifdef DAC_PENDING_EN
    wait_done(0, 300);
    tick();
`endif
    repeat (150) tick();
    check_frame(0, 12'h123, 2);
`ifdef DAC_PENDING_EN
    pop_rec(0, r);
    check("pend_frame", r.frame, exp_frame(12'h456));
    check("pend_gap", 32'(r.gap), 32'd1);
    check("pend_ovf", 32'(novf[0] - ov0), 32'd0);
    check("pend_done", 32'(ndone[0] - dn0), 32'd2);
`else
    check("drop_ovf", 32'(novf[0] - ov0), 32'd1);
    check("drop_done", 32'(ndone[0] - dn0), 32'd1);
`endif
    check("no_extra_frame", 32'(count_recs(0)), 32'd0);

    // Three starts: the third lands while the second is still outstanding.
    ov0 = novf[0];
    pulse(0, 12'h9E1);
    repeat (9) tick();
    pulse(0, 12'h2B7);
    repeat (9) tick();
    pulse(0, 12'hC4D);
    repeat (400) tick();
    check_frame(0, 12'h9E1, 2);
`ifdef DAC_PENDING_EN
    check("ovf_third", 32'(novf[0] - ov0), 32'd1);
    pop_rec(0, r);
    check("third_frame", r.frame, exp_frame(12'hC4D));
    check("third_gap", 32'(r.gap), 32'd1);
`else
    check("ovf_third", 32'(novf[0] - ov0), 32'd2);
`endif
    check("no_extra_frame2", 32'(count_recs(0)), 32'd0);

    // Reset after the 10th sck rise aborts the frame with no done.
    dn0 = ndone[0];
    pulse(0, 12'h777);
    for (int n = 0; n < 200 && nb[0] < 10; n++) tick();
    rst_n = 1'b0;
    #1;
    check("abort_pins", pins(0), 32'b100000);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    pop_rec(0, r);
    check("abort_bits", 32'(r.nbits), 32'd10);
    check("abort_no_done", 32'(ndone[0] - dn0), 32'd0);
    send(0, 12'h321);

    send(1, 12'h5A5);

    check("proto0", 32'(nviol[0]), 32'd0);
    check("proto1", 32'(nviol[1]), 32'd0);
    check("leftover", 32'(recs.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
